// File: rtl/rr_arbiter6.sv
// Six-way round-robin arbiter with a registered one-hot mux select and per-source ack pulses.
// Optional ARB6_BURST_EN lets a still-requesting source keep its grant for up to BURST_LEN transfers.
module rr_arbiter6 #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req,
    input  logic       out_ready,
    output logic [5:0] sel,
    output logic       out_valid,
    output logic [2:0] grant_idx,
    output logic [5:0] ack
);

    generate
        if ((1 << CNT_W) < BURST_LEN) begin : g_bad_burst_cfg
            $error("rr_arbiter6: CNT_W too narrow for BURST_LEN");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] sel_q, sel_d;
    logic [5:0] ack_q, ack_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_inc;
    logic       found;
    logic [2:0] pick_idx;
    logic       burst_more;

`ifdef ARB6_BURST_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign burst_more = req[idx_q] && ((int'(cnt_q) + 1) < BURST_LEN);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign burst_more = 1'b0;
`endif

    assign idx_inc = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        int c;
        found    = 1'b0;
        pick_idx = 3'd0;
        c        = 0;
        for (int k = 5; k >= 0; k--) begin
            c = int'(ptr_q) + k;
            if (c > 5) c = c - 6;
            if (req[c[2:0]]) begin
                found    = 1'b1;
                pick_idx = c[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            ack_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
`ifdef ARB6_BURST_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GRANT;
                    sel_d   = 6'd1 << pick_idx;
                    idx_d   = pick_idx;
`ifdef ARB6_BURST_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_GRANT: begin
                if (out_ready) begin
                    ack_d = sel_q;
                    if (burst_more) begin
`ifdef ARB6_BURST_EN
                        cnt_d = cnt_q + 1'b1;
`endif
                    end else begin
                        state_d = S_IDLE;
                        sel_d   = '0;
                        idx_d   = '0;
                        ptr_d   = idx_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sel       = sel_q;
        out_valid = |sel_q;
        grant_idx = idx_q;
        ack       = ack_q;
    end

endmodule

// File: tb/tb_rr_arbiter6.sv
// Directed bench for rr_arbiter6 in its default single-transfer build.
module tb_rr_arbiter6;

    logic       clk;
    logic       rst;
    logic [5:0] req;
    logic       out_ready;
    logic [5:0] sel;
    logic       out_valid;
    logic [2:0] grant_idx;
    logic [5:0] ack;

    int n_checks = 0;
    int n_errors = 0;

    rr_arbiter6 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .grant_idx (grant_idx),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_grant(input string tag, input int idx);
        logic [5:0] oh;
        oh = 6'd1 << idx;
        check({tag, "_sel"}, 32'(sel), 32'(oh));
        check({tag, "_idx"}, 32'(grant_idx), idx);
        check({tag, "_vld"}, 32'(out_valid), 1);
    endtask

    task automatic expect_ack(input string tag, input int idx);
        logic [5:0] oh;
        oh = 6'd1 << idx;
        check({tag, "_ack"}, 32'(ack), 32'(oh));
        check({tag, "_bub"}, 32'(sel), 0);
    endtask

    initial begin
        int order[7];
        order = '{3, 4, 5, 0, 1, 2, 3};
        rst       = 1'b1;
        req       = 6'b111111;
        out_ready = 1'b0;

        // Reset held with every source requesting.
        repeat (2) begin
            @(negedge clk);
            check("rst_sel", 32'(sel), 0);
            check("rst_vld", 32'(out_valid), 0);
            check("rst_ack", 32'(ack), 0);
            check("rst_idx", 32'(grant_idx), 0);
        end
        rst = 1'b0;
        req = 6'b000000;
        @(negedge clk);
        check("idle_sel", 32'(sel), 0);

        // Single request from source 2.
        req       = 6'b000100;
        out_ready = 1'b1;
        @(negedge clk);
        expect_grant("t2_grant", 2);
        req = 6'b000000;
        @(negedge clk);
        expect_ack("t2", 2);

        // All requesting: rotation starts at 3 because ptr moved past 2.
        req = 6'b111111;
        foreach (order[i]) begin
            @(negedge clk);
            expect_grant($sformatf("t3_g%0d", i), order[i]);
            @(negedge clk);
            expect_ack($sformatf("t3_a%0d", i), order[i]);
        end
        req = 6'b000000;

        // Grant 4 so ptr=5, then wrap to 0 and 1.
        req = 6'b010000;
        @(negedge clk);
        expect_grant("t4_g4", 4);
        req = 6'b000011;
        @(negedge clk);
        expect_ack("t4_a4", 4);
        @(negedge clk);
        expect_grant("t4_g0", 0);
        req = 6'b000010;
        @(negedge clk);
        expect_ack("t4_a0", 0);
        @(negedge clk);
        expect_grant("t4_g1", 1);
        req = 6'b000000;
        @(negedge clk);
        expect_ack("t4_a1", 1);

        // Backpressure: grant to 3 held while req changes underneath it.
        req       = 6'b001000;
        out_ready = 1'b0;
        @(negedge clk);
        expect_grant("t5_g3", 3);
        req = 6'b000010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t5_hold%0d_sel", i), 32'(sel), 32'(6'b001000));
            check($sformatf("t5_hold%0d_ack", i), 32'(ack), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        expect_ack("t5_a3", 3);
        @(negedge clk);
        expect_grant("t5_g1", 1);
        req = 6'b000000;
        @(negedge clk);
        expect_ack("t5_a1", 1);

        // Reset mid-grant drops the transfer and clears ptr.
        req       = 6'b000001;
        out_ready = 1'b0;
        @(negedge clk);
        expect_grant("t6_g0", 0);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_rst_sel", 32'(sel), 0);
        check("t6_rst_vld", 32'(out_valid), 0);
        check("t6_rst_ack", 32'(ack), 0);
        rst = 1'b0;
        req = 6'b000000;
        @(negedge clk);
        check("t6_noack", 32'(ack), 0);
        req = 6'b100001;
        @(negedge clk);
        expect_grant("t6_ptr0", 0);
        req = 6'b000000;
        @(negedge clk);
        expect_ack("t6_a0", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
